// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or shift-subtract step per cycle
//   in : clk, rst_n (async, active low), start, flush, funct3, op_a (rs1), op_b (rs2), rd_in
//   out: busy (stall issue), done (we3 pulse), result (wd3), rd_out (ad3)
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  input  logic [ADDRESS_WIDTH-1:0] rd_in,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] rd_out
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               op_q, op_d;
  logic                     neg_q, neg_d;
  logic [W-1:0]             m_q, m_d, result_q, result_d;
  logic [2*W-1:0]           acc_q, acc_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic                     is_div, a_neg, b_neg, accept, ge;
  logic [W-1:0]             a_abs, b_abs, diff, rq, rn;
  logic [W:0]               sum, trial;
  logic [2*W-1:0]           prod;
  assign is_div = funct3[2];
  assign a_neg  = op_a[W-1] & (is_div ? ~funct3[0] : funct3[1] ^ funct3[0]);
  assign b_neg  = op_b[W-1] & (is_div ? ~funct3[0] : funct3[1:0] == 2'b01);
  assign a_abs  = a_neg ? -op_a : op_a;
  assign b_abs  = b_neg ? -op_b : op_b;
  assign accept = start & ~flush & (state_q == IDLE || state_q == DONE);
  // acc holds {high product, multiplier} for mul and {remainder, dividend/quotient} for div
  assign sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, acc_q[0] ? m_q : {W{1'b0}}};
  assign trial  = acc_q[2*W-1:W-1];
  assign ge     = trial >= {1'b0, m_q};
  // when ge the difference is below the divisor, so W bits suffice
  assign diff   = trial[W-1:0] - m_q;
  assign prod   = neg_q ? -acc_q : acc_q;
  assign rq     = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
  assign rn     = neg_q ? -rq : rq;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    m_d      = m_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = accept ? RUN : IDLE;
        if (accept) begin
          cnt_d = '0;
          op_d  = funct3;
          rd_d  = rd_in;
          // divide by zero keeps the quotient all ones and the remainder equal to op_a
          neg_d = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg) & (~is_div | (|op_b));
          m_d   = is_div ? b_abs : a_abs;
          acc_d = {{W{1'b0}}, is_div ? a_abs : b_abs};
        end
      end
      RUN: begin
        state_d = flush ? IDLE : (cnt_q == CW'(W - 1) ? FIX : RUN);
        cnt_d   = cnt_q + 1'b1;
        acc_d   = op_q[2] ? {ge ? diff : trial[W-1:0], acc_q[W-2:0], ge} : {sum, acc_q[W-1:1]};
      end
      FIX: begin
        state_d = flush ? IDLE : DONE;
        if (!flush) begin
          result_d = op_q[2] ? rn : (op_q[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]);
          rd_out_d = rd_q;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end
  assign busy   = state_q == RUN || state_q == FIX;
  assign done   = state_q == DONE;
  assign result = result_q;
  assign rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  localparam int W = 32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [31:0] m_res = '0, p_res = '0;
  logic [4:0]  m_rd = '0, p_rd = '0;
  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // k counts cycles since acceptance: 1..W+1 busy, W+2 done, 0 idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      m_res <= '0;
      m_rd <= '0;
    end else if (k == 0 || k == W + 2) begin
      if (start && !flush) begin
        k <= 1;
        p_res <= ref_op(funct3, op_a, op_b);
        p_rd <= rd_in;
      end else k <= 0;
    end else if (flush) k <= 0;
    else begin
      k <= k + 1;
      if (k + 1 == W + 2) begin
        m_res <= p_res;
        m_rd <= p_rd;
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, k >= 1 && k <= W + 1});
    chk("done", {31'b0, done}, {31'b0, k == W + 2});
    chk("result", result, m_res);
    chk("rd_out", {27'b0, rd_out}, {27'b0, m_rd});
  end
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3 = f;
    op_a = a;
    op_b = b;
    rd_in = rd;
    start = 1'b1;
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic run_ctl(input int restart_at, input int flush_at, output int lat, output int ndone, output logic b1, output logic b11);
    lat = -1;
    ndone = 0;
    b1 = 1'b0;
    b11 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        lat = i;
      end
      if (i == 1) b1 = busy;
      if (i == 11) b11 = busy;
      start = (i == restart_at);
      flush = (i == flush_at);
    end
    start = 1'b0;
    flush = 1'b0;
  endtask
  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int lat;
    chk({name, "_model"}, ref_op(f, a, b), e);
    issue(f, a, b, 5'd5);
    wait_done(lat);
    chk({name, "_latency"}, 32'(lat), 32'd34);
    chk({name, "_result"}, result, e);
    chk({name, "_rd"}, {27'b0, rd_out}, 32'd5);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int lat, nd;
    logic b1, b11;
    #3;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    directed("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    directed("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    directed("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    directed("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    directed("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    directed("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    directed("remu0", 3'd7, 32'd5, 32'd0, 32'd5);
    directed("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue(3'd0, 32'd3, 32'd4, 5'd9);
    run_ctl(10, 0, lat, nd, b1, b11);
    chk("restart_ndone", 32'(nd), 32'd1);
    chk("restart_latency", 32'(lat), 32'd34);
    chk("restart_result", result, 32'd12);
    issue(3'd5, 32'd50, 32'd5, 5'd3);
    run_ctl(0, 10, lat, nd, b1, b11);
    chk("flush_ndone", 32'(nd), 32'd0);
    chk("flush_busy_c11", {31'b0, b11}, 32'd0);
    chk("flush_result_held", result, 32'd12);
    issue(3'd5, 32'd50, 32'd5, 5'd3);
    flush = 1'b1;
    run_ctl(0, 0, lat, nd, b1, b11);
    chk("startflush_ndone", 32'(nd), 32'd0);
    chk("startflush_busy", {31'b0, b1}, 32'd0);
    issue(3'd5, 32'd90, 32'd9, 5'd4);
    wait_done(lat);
    chk("b2b_first", result, 32'd10);
    issue(3'd7, 32'd90, 32'd7, 5'd6);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'd34);
    chk("b2b_result", result, 32'd6);
    chk("b2b_rd", {27'b0, rd_out}, 32'd6);
    issue(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd7);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_done", {31'b0, done}, 32'd0);
    chk("async_result", result, 32'd0);
    chk("async_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd7);
    wait_done(lat);
    chk("post_reset_latency", 32'(lat), 32'd34);
    chk("post_reset_result", result, 32'd1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      flush = ($urandom % 64) == 0;
      funct3 = 3'($urandom);
      op_a = pick();
      op_b = pick();
      rd_in = 5'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
